// File: rtl/pcie_rst_pkg.sv
// pcie_rst_pkg: shared state encoding and default parameters for the PCIe reset sequencer
package pcie_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_INIT    = 2'd0,
        WAIT_LOCK    = 2'd1,
        RELEASE_PCIE = 2'd2,
        RUN          = 2'd3
    } rst_state_e;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_LOCK_FILTER    = 8;
    localparam int DEF_STRETCH_CYCLES = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcie_reset_sequencer_sync_bit.sv
// sync_bit: N-stage asynchronous-reset synchronizer, resets to 0
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pcie_reset_sequencer.sv
// pcie_reset_sequencer: ordered synchronous-deassert resets for PCIe and user fabric
module pcie_reset_sequencer
    import pcie_rst_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
    parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       CLK,
    input  logic       FABRIC_POR_N,
    input  logic       PCIE_INIT_DONE,
    input  logic       DEVICE_INIT_DONE,
    input  logic       BANK_0_CALIB_STATUS,
    input  logic       BANK_1_CALIB_STATUS,
    input  logic       PLL_LOCK,
    input  logic       EXT_RST_N,
    output logic       PCIE_RESET_N,
    output logic       FABRIC_RESET_N,
    output logic       READY,
    output logic       INIT_TIMEOUT,
    output logic [1:0] STATE
);

    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam int LW = cnt_width(LOCK_FILTER);
    localparam int SW = cnt_width(STRETCH_CYCLES);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FILTER - 1);
    localparam logic [SW-1:0] STR_MAX  = SW'(STRETCH_CYCLES - 1);

    logic [5:0]    async_in;
    logic [5:0]    sync_q;
    logic          init_ok;
    logic          lock_s;
    logic          ext_s;
    logic          lock_done;
    logic [TW-1:0] tmo_cnt;
    logic [LW-1:0] lock_cnt;
    logic [SW-1:0] str_cnt;
    rst_state_e    state;
    rst_state_e    nxt;

    assign async_in = {PCIE_INIT_DONE, DEVICE_INIT_DONE, BANK_0_CALIB_STATUS,
                       BANK_1_CALIB_STATUS, PLL_LOCK, EXT_RST_N};

    for (genvar i = 0; i < 6; i++) begin : g_sync
        sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (CLK),
            .rst_n (FABRIC_POR_N),
            .d     (async_in[i]),
            .q     (sync_q[i])
        );
    end

    assign init_ok   = &sync_q[5:2];
    assign lock_s    = sync_q[1];
    assign ext_s     = sync_q[0];
    assign lock_done = lock_s && (lock_cnt == LOCK_MAX);
    assign STATE     = state;

    // next state: aborts (external reset, init loss, lock loss) outrank forward progress
    always_comb begin
        nxt = state;
        if (state == WAIT_INIT) nxt = (init_ok && ext_s) ? WAIT_LOCK : WAIT_INIT;
        else if (!ext_s || !init_ok) nxt = WAIT_INIT;
        else if (!lock_s && state != WAIT_LOCK) nxt = WAIT_LOCK;
        else if (state == WAIT_LOCK && lock_done) nxt = RELEASE_PCIE;
        else if (state == RELEASE_PCIE && str_cnt == STR_MAX) nxt = RUN;
    end

    // state, counters and outputs decoded from next state so they move on the same edge
    always_ff @(posedge CLK or negedge FABRIC_POR_N) begin
        if (!FABRIC_POR_N) begin
            state          <= WAIT_INIT;
            tmo_cnt        <= '0;
            lock_cnt       <= '0;
            str_cnt        <= '0;
            PCIE_RESET_N   <= 1'b0;
            FABRIC_RESET_N <= 1'b0;
            READY          <= 1'b0;
            INIT_TIMEOUT   <= 1'b0;
        end else begin
            state          <= nxt;
            tmo_cnt        <= (state != WAIT_INIT) ? '0 : (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
            lock_cnt       <= (state == WAIT_LOCK && lock_s && !lock_done) ? lock_cnt + 1'b1 : '0;
            str_cnt        <= (state == RELEASE_PCIE && nxt == RELEASE_PCIE) ? str_cnt + 1'b1 : '0;
            PCIE_RESET_N   <= (nxt == RELEASE_PCIE) || (nxt == RUN);
            FABRIC_RESET_N <= (nxt == RUN);
            READY          <= (nxt == RUN);
            if (state == WAIT_INIT && tmo_cnt == TMO_MAX) INIT_TIMEOUT <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pcie_reset_sequencer.sv
// tb_pcie_reset_sequencer: scoreboard bench with directed scenarios and randomized input chatter
module tb_pcie_reset_sequencer;

    localparam int SS = 2;
    localparam int LF = 8;
    localparam int ST = 16;
    localparam int TO = 1024;

    logic       clk = 1'b0;
    logic       por_n;
    logic       pcie_done, dev_done, b0, b1, pll, ext;
    logic       pcie_rst_n, fab_rst_n, ready, tmo;
    logic [1:0] state;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [5:0] sb[$];
    logic [5:0] hist[$];
    logic [5:0] mon_exp;
    int         m_phase, m_wait, m_lock, m_rel;
    bit         m_tmo;
    int         lowc[6];
    int         por_hold;

    always #5 clk = ~clk;

    pcie_reset_sequencer #(
        .SYNC_STAGES    (SS),
        .LOCK_FILTER    (LF),
        .STRETCH_CYCLES (ST),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK                 (clk),
        .FABRIC_POR_N        (por_n),
        .PCIE_INIT_DONE      (pcie_done),
        .DEVICE_INIT_DONE    (dev_done),
        .BANK_0_CALIB_STATUS (b0),
        .BANK_1_CALIB_STATUS (b1),
        .PLL_LOCK            (pll),
        .EXT_RST_N           (ext),
        .PCIE_RESET_N        (pcie_rst_n),
        .FABRIC_RESET_N      (fab_rst_n),
        .READY               (ready),
        .INIT_TIMEOUT        (tmo),
        .STATE               (state)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int outs();
        return int'({state, pcie_rst_n, fab_rst_n, ready, tmo});
    endfunction

    task automatic apply(input logic [5:0] v);
        {pcie_done, dev_done, b0, b1, pll, ext} = v;
    endtask

    // reference: inputs seen SS edges late; phase 0..3 advanced by plain run-length counting
    task automatic model_edge();
        logic [5:0] s;
        bit init_ok, lock_s, ext_s;
        if (!por_n) begin
            m_phase = 0; m_wait = 0; m_lock = 0; m_rel = 0; m_tmo = 0;
            hist = {};
            repeat (SS) hist.push_back(6'b0);
            sb.push_back(6'b0);
            return;
        end
        s = hist.pop_front();
        hist.push_back({pcie_done, dev_done, b0, b1, pll, ext});
        init_ok = &s[5:2];
        lock_s  = s[1];
        ext_s   = s[0];
        if (m_phase == 0) begin
            if (m_wait >= TO - 1) m_tmo = 1;
            m_wait++;
            if (init_ok && ext_s) begin m_phase = 1; m_lock = 0; end
        end else if (!ext_s || !init_ok) begin
            m_phase = 0; m_wait = 0;
        end else if (!lock_s && m_phase >= 2) begin
            m_phase = 1; m_lock = 0;
        end else if (m_phase == 1) begin
            m_lock = lock_s ? m_lock + 1 : 0;
            if (m_lock == LF) begin m_phase = 2; m_rel = 0; end
        end else if (m_phase == 2) begin
            m_rel++;
            if (m_rel == ST) m_phase = 3;
        end
        sb.push_back({2'(m_phase), m_phase >= 2, m_phase == 3, m_phase == 3, m_tmo});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #2;
    endtask

    // monitor: every edge the DUT presents a fresh output word; compare against the scoreboard
    initial forever begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            mon_exp = sb.pop_front();
            chk("sb_outputs", outs(), int'(mon_exp));
        end
    end

    initial begin
        por_n = 1'b0;
        apply(6'b0);
        tick();
        tick();
        chk("reset_outputs", outs(), 0);

        apply(6'h3f);
        por_n = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            tick();
            if (e == 2) chk("bringup_state_e2", state, 0);
            if (e == 3) chk("bringup_state_e3", state, 1);
            if (e == 10) chk("bringup_pcie_e10", pcie_rst_n, 0);
            if (e == 11) chk("bringup_pcie_e11", pcie_rst_n, 1);
            if (e == 26) chk("bringup_ready_e26", ready, 0);
            if (e == 27) chk("bringup_run_e27", {fab_rst_n, ready, state}, 7'b1_1_11);
        end

        pll = 1'b0;
        tick();
        pll = 1'b1;
        for (int e = 2; e <= 27; e++) begin
            tick();
            if (e == 2) chk("lockloss_ready_e2", ready, 1);
            if (e == 3) chk("lockloss_e3", {pcie_rst_n, fab_rst_n, state}, 4'b0_0_01);
            if (e == 26) chk("lockloss_ready_e26", ready, 0);
            if (e == 27) chk("lockloss_ready_e27", ready, 1);
        end

        ext = 1'b0;
        pll = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            if (e == 2) chk("prio_state_e2", state, 3);
            if (e == 3) chk("prio_e3", {pcie_rst_n, fab_rst_n, state}, 4'b0_0_00);
        end
        ext = 1'b1;
        pll = 1'b1;
        repeat (30) tick();
        chk("prio_recover_ready", ready, 1);

        por_n = 1'b0;
        tick();
        apply(6'h3d);
        por_n = 1'b1;
        for (int e = 1; e <= 21; e++) begin
            if (e >= 4) pll = (e == 11) ? 1'b0 : 1'b1;
            tick();
            if (e == 3) chk("chatter_wait_lock", state, 1);
            if (e == 13) chk("chatter_pcie_e13", pcie_rst_n, 0);
            if (e == 20) chk("chatter_pcie_e20", pcie_rst_n, 0);
            if (e == 21) chk("chatter_release_e21", {pcie_rst_n, state}, 3'b1_10);
        end

        repeat (3) tick();
        chk("midpor_in_release", state, 2);
        por_n = 1'b0;
        #1;
        chk("midpor_async_clear", outs(), 0);
        tick();

        apply(6'h3f);
        dev_done = 1'b0;
        por_n = 1'b1;
        for (int e = 1; e <= 1024; e++) begin
            tick();
            if (e == 1023) chk("timeout_e1023", tmo, 0);
            if (e == 1024) chk("timeout_e1024", {tmo, state}, 3'b1_00);
        end
        dev_done = 1'b1;
        repeat (27) tick();
        chk("timeout_bringup", {ready, tmo}, 2'b11);

        for (int i = 0; i < 6; i++) lowc[i] = 0;
        por_hold = 0;
        for (int c = 0; c < 4000; c++) begin
            logic [5:0] v;
            for (int i = 0; i < 6; i++) begin
                if (lowc[i] > 0) lowc[i]--;
                else if ($urandom_range(0, 199) == 0) lowc[i] = $urandom_range(1, 6);
                v[i] = (lowc[i] == 0);
            end
            apply(v);
            if (por_hold > 0) por_hold--;
            else if ($urandom_range(0, 999) == 0) por_hold = $urandom_range(1, 3);
            por_n = (por_hold == 0);
            tick();
        end

        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pcie_reset_sequencer.md
# pcie_reset_sequencer

Reset sequencer that consumes the init-monitor status outputs (`FABRIC_POR_N`, `PCIE_INIT_DONE`, `DEVICE_INIT_DONE`, bank calibration status) plus the fabric PLL lock. It produces ordered, synchronous-deassert resets for the PCIe subsystem and the user fabric. It sits directly downstream of the PCIe init monitor and upstream of every reset consumer in the PCIe clock domain.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for every asynchronous input (min 2).
- `LOCK_FILTER`, 8: consecutive synchronized-high `PLL_LOCK` samples required in WAIT_LOCK.
- `STRETCH_CYCLES`, 16: cycles `PCIE_RESET_N` is released before `FABRIC_RESET_N`.
- `TIMEOUT_CYCLES`, 1024: WAIT_INIT cycles before `INIT_TIMEOUT` is flagged.

Ports:
- `CLK` input 1: fabric clock; the block has exactly one clock.
- `FABRIC_POR_N` input 1: reset, asynchronous, active-low. Clears every flop, including synchronizers.
- `PCIE_INIT_DONE` input 1: asynchronous, level.
- `DEVICE_INIT_DONE` input 1: asynchronous, level.
- `BANK_0_CALIB_STATUS`, `BANK_1_CALIB_STATUS` input 1 each: asynchronous, level.
- `PLL_LOCK` input 1: asynchronous, level.
- `EXT_RST_N` input 1: asynchronous, active-low external reset request.
- `PCIE_RESET_N` output 1: PCIe-domain reset, active-low, registered.
- `FABRIC_RESET_N` output 1: user-fabric reset, active-low, registered.
- `READY` output 1: high only in RUN.
- `INIT_TIMEOUT` output 1: sticky; cleared only by `FABRIC_POR_N`.
- `STATE` output 2: current state encoding, for debug.

## Operation
- Each of the six asynchronous inputs passes through a `SYNC_STAGES`-flop synchronizer that resets to 0. The synchronized versions are `*_s`.
- `init_ok` = `PCIE_INIT_DONE_s & DEVICE_INIT_DONE_s & BANK_0_CALIB_STATUS_s & BANK_1_CALIB_STATUS_s`.
- States and encodings: WAIT_INIT=0, WAIT_LOCK=1, RELEASE_PCIE=2, RUN=3. The state resets to WAIT_INIT.
- WAIT_INIT:
  - `init_ok & EXT_RST_N_s` → WAIT_LOCK.
  - `tmo_cnt` increments each cycle. At `tmo_cnt == TIMEOUT_CYCLES-1`, `INIT_TIMEOUT` is set. The counter saturates and the state does not change.
- WAIT_LOCK:
  - `lock_cnt` is cleared on entry and cleared on any `PLL_LOCK_s=0` cycle.
  - `lock_cnt` increments on each `PLL_LOCK_s=1` cycle.
  - When `lock_cnt == LOCK_FILTER-1` and `PLL_LOCK_s=1` → RELEASE_PCIE.
- RELEASE_PCIE: `str_cnt` is cleared on entry. When `str_cnt == STRETCH_CYCLES-1` → RUN.
- RUN: terminal while all conditions hold.
- Abort priority, evaluated in every state except WAIT_INIT, highest first:
  1. `EXT_RST_N_s=0` → WAIT_INIT.
  2. `init_ok=0` → WAIT_INIT.
  3. `PLL_LOCK_s=0` in RELEASE_PCIE or RUN → WAIT_LOCK.
- Output decode, registered and derived from next-state so outputs change in the same edge as the state:
  - `PCIE_RESET_N` = 1 in RELEASE_PCIE and RUN.
  - `FABRIC_RESET_N` and `READY` = 1 in RUN only.
- Counter widths are `$clog2` of the respective parameter, minimum 1 bit. Counters never wrap.

## Timing
- Reset values:
  - `PCIE_RESET_N`=0, `FABRIC_RESET_N`=0, `READY`=0, `INIT_TIMEOUT`=0, `STATE`=0.
  - All synchronizers and counters = 0.
- Assertion of `FABRIC_POR_N` forces all outputs to reset values asynchronously. Deassertion is consumed synchronously.
- Nominal bring-up, with all inputs high before edge 0:
  - Synchronized values are high after edge `SYNC_STAGES`.
  - WAIT_LOCK is entered at edge `SYNC_STAGES+1`.
  - RELEASE_PCIE is entered `LOCK_FILTER` edges later.
  - RUN is entered `STRETCH_CYCLES` edges after that.
- Abort latency: `SYNC_STAGES+1` edges from the input falling to the resets asserting.
- Simultaneous `EXT_RST_N` low and lock loss: `EXT_RST_N` wins, so the next state is WAIT_INIT.
- An input glitch shorter than one `CLK` period may be missed. This is accepted behaviour.
- A lock-loss pulse in WAIT_LOCK restarts the filter without a state change.

## Structure
- Shared package `pcie_rst_pkg`: state enum `rst_state_e` with the 2-bit encodings above, plus default parameter constants.
- One sub-module, `sync_bit`: an N-stage async-reset synchronizer with a `STAGES` parameter, instantiated six times.
- The FSM and counters live in the top module.

## Test plan
All scenarios use default parameters.
- Bring-up: release POR, then drive all inputs high before edge 0.
  - Expect `STATE`=1 at edge 3.
  - Expect `PCIE_RESET_N`=1 at edge 11.
  - Expect `FABRIC_RESET_N`=`READY`=1 at edge 27.
- Lock loss: in RUN, drop `PLL_LOCK` for 1 cycle (sampled).
  - Expect both resets low 3 edges later and `STATE`=1.
  - Expect RUN again 24 edges after lock returns to synchronized-high.
- Lock chatter: in WAIT_LOCK, hold lock high for 7 cycles, low for 1, then high.
  - Expect RELEASE_PCIE only after 8 further consecutive high cycles.
- Timeout: hold `DEVICE_INIT_DONE`=0.
  - Expect `INIT_TIMEOUT`=1 after 1024 WAIT_INIT cycles.
  - After raising `DEVICE_INIT_DONE`, expect bring-up to complete with `INIT_TIMEOUT` still 1.
- Priority: in RUN, drop `EXT_RST_N` and `PLL_LOCK` in the same cycle.
  - Expect `STATE`=0, both resets low 3 edges later.
- Mid-sequence POR: assert `FABRIC_POR_N` while in RELEASE_PCIE.
  - Expect all outputs at reset values immediately, with no clock edge required.
